// File: rtl/pipe_fetch.sv
// Fetch stage of the pipelined Y86-64 processor.
// Selects the fetch PC (predicted, mispredict correction, or ret return address),
// splits and aligns the instruction bytes, computes valP and the next predicted PC,
// and loads the F (predPC) and D pipeline registers under stall/bubble control.
module pipe_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_bytes,
  input  logic        imem_error,
  output logic [63:0] F_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  // Status codes
  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  // Instruction codes referenced by the fetch logic
  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] IRrmovq = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  localparam logic [3:0] RNone = 4'hF;

  logic [63:0] f_pc;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_ra;
  logic [3:0]  f_rb;
  logic [63:0] f_valc;
  logic [63:0] f_valp;
  logic [2:0]  f_stat;
  logic [63:0] f_predpc;
  logic        instr_valid;
  logic        need_regids;
  logic        need_valc;

  // PC select: a not-taken jump in M has priority over a ret in W
  always_comb begin
    if (M_icode == IJxx && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == IRet) begin
      f_pc = W_valM;
    end else begin
      f_pc = F_predPC;
    end
  end

  assign imem_addr = f_pc;

  // Split byte 0; an address fault turns the fetch into a nop-shaped instruction
  always_comb begin
    if (imem_error) begin
      f_icode = INop;
      f_ifun  = 4'h0;
    end else begin
      f_icode = imem_bytes[7:4];
      f_ifun  = imem_bytes[3:0];
    end
  end

  // Decode which optional fields the instruction carries
  always_comb begin
    instr_valid = (f_icode <= IPopq);
    need_regids = 1'b0;
    need_valc   = 1'b0;
    unique case (f_icode)
      IRrmovq, IOpq, IPushq, IPopq: need_regids = 1'b1;
      IIrmovq, IRmmovq, IMrmovq: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      IJxx, ICall: need_valc = 1'b1;
      default: begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
      end
    endcase
  end

  // Align register specifiers and the 8-byte little-endian constant
  always_comb begin
    if (need_regids) begin
      f_ra = imem_bytes[15:12];
      f_rb = imem_bytes[11:8];
    end else begin
      f_ra = RNone;
      f_rb = RNone;
    end
    if (!need_valc) begin
      f_valc = 64'h0;
    end else if (need_regids) begin
      f_valc = imem_bytes[79:16];
    end else begin
      f_valc = imem_bytes[71:8];
    end
  end

  // Fall-through PC; wraps silently modulo 2^64
  always_comb begin
    f_valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
  end

  // Status, first match wins
  always_comb begin
    if (imem_error) begin
      f_stat = StatAdr;
    end else if (!instr_valid) begin
      f_stat = StatIns;
    end else if (f_icode == IHalt) begin
      f_stat = StatHlt;
    end else begin
      f_stat = StatAok;
    end
  end

  // Predict taken for jumps and calls; ret predicts valP and is corrected from W
  always_comb begin
    if (f_icode == IJxx || f_icode == ICall) begin
      f_predpc = f_valc;
    end else begin
      f_predpc = f_valp;
    end
  end

  // F register: reset, hold on stall, else take the prediction
  always_ff @(posedge Clk) begin
    if (Reset) begin
      F_predPC <= RESET_PC;
    end else if (!F_stall) begin
      F_predPC <= f_predpc;
    end
  end

  // D register: reset and bubble both load a nop; bubble beats stall
  always_ff @(posedge Clk) begin
    if (Reset || D_bubble) begin
      D_stat  <= StatAok;
      D_icode <= INop;
      D_ifun  <= 4'h0;
      D_rA    <= RNone;
      D_rB    <= RNone;
      D_valC  <= 64'h0;
      D_valP  <= 64'h0;
    end else if (!D_stall) begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_ra;
      D_rB    <= f_rb;
      D_valC  <= f_valc;
      D_valP  <= f_valp;
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: directed table of vectors, then randomized traffic
// checked against an instruction-length based reference model.
module tb_pipe_fetch;

  logic        Clk = 1'b0;
  logic        Reset, F_stall, D_stall, D_bubble, M_Cnd, imem_error;
  logic [3:0]  M_icode, W_icode;
  logic [63:0] M_valA, W_valM;
  logic [79:0] imem_bytes;
  logic [63:0] imem_addr, F_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  always #5 Clk = ~Clk;

  pipe_fetch #(.RESET_PC(64'h0)) dut (
    .Clk(Clk), .Reset(Reset), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
    .imem_addr(imem_addr), .imem_bytes(imem_bytes), .imem_error(imem_error),
    .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  typedef struct {
    logic        rst, fst, dst, dbub;
    logic [3:0]  mi;
    logic        mc;
    logic [63:0] ma;
    logic [3:0]  wi;
    logic [63:0] wm;
    logic [79:0] b;
    logic        err;
  } in_t;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } dreg_t;

  typedef struct {
    in_t         i;
    logic        chk_addr;
    logic [63:0] addr;
    logic [63:0] pred;
    dreg_t       d;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [63:0] m_pred;
  dreg_t       m_d;
  logic [63:0] m_addr;

  localparam logic [79:0] NOP = 80'h10;
  localparam logic [79:0] IRM = 80'h0102030405060708F330;
  localparam logic [79:0] JNE = 80'h00000000000000010074;

  function automatic in_t mk(logic rst, logic fst, logic dst, logic dbub, logic [3:0] mi,
                             logic mc, logic [63:0] ma, logic [3:0] wi, logic [63:0] wm,
                             logic [79:0] b, logic err);
    in_t v;
    v.rst = rst; v.fst = fst; v.dst = dst; v.dbub = dbub; v.mi = mi; v.mc = mc;
    v.ma = ma; v.wi = wi; v.wm = wm; v.b = b; v.err = err;
    return v;
  endfunction

  function automatic dreg_t mkd(logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                                logic [3:0] ra, logic [3:0] rb, logic [63:0] valc,
                                logic [63:0] valp);
    dreg_t d;
    d.stat = stat; d.icode = icode; d.ifun = ifun; d.ra = ra; d.rb = rb;
    d.valc = valc; d.valp = valp;
    return d;
  endfunction

  function automatic dreg_t bub();
    return mkd(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
  endfunction

  // Encoded length in bytes of each instruction class; unknown codes occupy one byte
  function automatic int ilen(logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9: return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5: return 10;
      4'h7, 4'h8: return 9;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(logic [79:0] b, int k);
    return b[8*k +: 8];
  endfunction

  function automatic logic [63:0] model_pc(in_t v, logic [63:0] pred);
    if (v.mi == 4'h7 && !v.mc) return v.ma;
    if (v.wi == 4'h9) return v.wm;
    return pred;
  endfunction

  function automatic dreg_t model_fetch(in_t v, logic [63:0] pc);
    dreg_t d;
    int    len;
    bit    has_reg, has_c;
    logic [7:0] b0;
    b0 = byte_at(v.b, 0);
    d.icode = v.err ? 4'h1 : b0[7:4];
    d.ifun  = v.err ? 4'h0 : b0[3:0];
    len = ilen(d.icode);
    has_reg = (len == 2 || len == 10);
    has_c   = (len == 9 || len == 10);
    d.ra = 4'hF;
    d.rb = 4'hF;
    if (has_reg) begin
      d.ra = byte_at(v.b, 1) >> 4;
      d.rb = byte_at(v.b, 1) & 8'h0F;
    end
    d.valc = 64'h0;
    if (has_c) begin
      for (int k = 0; k < 8; k++) begin
        d.valc = d.valc | (64'(byte_at(v.b, (has_reg ? 2 : 1) + k)) << (8 * k));
      end
    end
    d.valp = pc + 64'(len);
    if (v.err) d.stat = 3'd3;
    else if (d.icode > 4'hB) d.stat = 3'd4;
    else if (d.icode == 4'h0) d.stat = 3'd2;
    else d.stat = 3'd1;
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(string tag, logic [63:0] pred, dreg_t e);
    chk({tag, " F_predPC"}, F_predPC, pred);
    chk({tag, " D_stat"}, 64'(D_stat), 64'(e.stat));
    chk({tag, " D_icode"}, 64'(D_icode), 64'(e.icode));
    chk({tag, " D_ifun"}, 64'(D_ifun), 64'(e.ifun));
    chk({tag, " D_rA"}, 64'(D_rA), 64'(e.ra));
    chk({tag, " D_rB"}, 64'(D_rB), 64'(e.rb));
    chk({tag, " D_valC"}, D_valC, e.valc);
    chk({tag, " D_valP"}, D_valP, e.valp);
  endtask

  // Drive one cycle of inputs, sample imem_addr mid-cycle, clock, then advance the model
  task automatic run_cycle(in_t v, output logic [63:0] addr_seen);
    dreg_t f;
    logic [63:0] pc, nxt;
    Reset = v.rst; F_stall = v.fst; D_stall = v.dst; D_bubble = v.dbub;
    M_icode = v.mi; M_Cnd = v.mc; M_valA = v.ma; W_icode = v.wi; W_valM = v.wm;
    imem_bytes = v.b; imem_error = v.err;
    #2;
    addr_seen = imem_addr;
    pc = model_pc(v, m_pred);
    m_addr = pc;
    f = model_fetch(v, pc);
    nxt = (f.icode == 4'h7 || f.icode == 4'h8) ? f.valc : f.valp;
    @(posedge Clk);
    if (v.rst) m_pred = 64'h0;
    else if (!v.fst) m_pred = nxt;
    if (v.rst || v.dbub) m_d = bub();
    else if (!v.dst) m_d = f;
    #1;
  endtask

  vec_t vecs[20];

  initial begin
    logic [63:0] a;
    in_t r;
    logic [7:0] b0;

    vecs[0]  = '{mk(1,0,0,0,0,0,0,0,0,80'hDEADBEEF,0), 0, 64'h0, 64'h0, bub()};
    vecs[1]  = '{mk(1,1,0,1,0,0,0,0,0,IRM,1), 1, 64'h0, 64'h0, bub()};
    vecs[2]  = '{mk(0,0,0,0,0,0,0,0,0,IRM,0), 1, 64'h0, 64'd10,
                 mkd(1, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'd10)};
    vecs[3]  = '{mk(0,0,0,0,7,0,64'h20,0,0,JNE,0), 1, 64'h20, 64'h100,
                 mkd(1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h29)};
    vecs[4]  = '{mk(0,0,0,0,7,0,64'h29,0,0,NOP,0), 1, 64'h29, 64'h2A,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2A)};
    vecs[5]  = '{mk(0,0,0,0,7,0,64'h4F,0,0,NOP,0), 1, 64'h4F, 64'h50,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h50)};
    vecs[6]  = '{mk(0,0,0,0,0,0,0,9,64'h4000,NOP,0), 1, 64'h4000, 64'h4001,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4001)};
    vecs[7]  = '{mk(0,0,0,0,0,0,0,0,0,IRM,1), 1, 64'h4001, 64'h4002,
                 mkd(3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4002)};
    vecs[8]  = '{mk(0,0,0,0,0,0,0,0,0,80'hC0,0), 1, 64'h4002, 64'h4003,
                 mkd(4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4003)};
    vecs[9]  = '{mk(0,0,0,0,0,0,0,0,0,80'h00,0), 1, 64'h4003, 64'h4004,
                 mkd(2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4004)};
    for (int k = 10; k < 13; k++) begin
      vecs[k] = '{mk(0,1,1,0,0,0,0,0,0,IRM,0), 1, 64'h4004, 64'h4004,
                  mkd(2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h4004)};
    end
    vecs[13] = '{mk(0,0,1,1,0,0,0,0,0,NOP,0), 1, 64'h4004, 64'h4005, bub()};
    vecs[14] = '{mk(0,0,0,0,7,0,64'hFFFF_FFFF_FFFF_FFFE,0,0,80'h1220,0), 1,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, mkd(1, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0)};
    vecs[15] = '{mk(1,1,1,1,7,0,64'h77,9,64'h5000,IRM,0), 1, 64'h77, 64'h0, bub()};
    vecs[16] = '{mk(0,0,0,0,0,0,0,0,0,NOP,0), 1, 64'h0, 64'h1,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1)};
    vecs[17] = '{mk(0,0,0,0,7,0,64'h300,9,64'h4000,NOP,0), 1, 64'h300, 64'h301,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301)};
    vecs[18] = '{mk(0,0,0,0,7,1,64'h999,0,0,NOP,0), 1, 64'h301, 64'h302,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h302)};
    vecs[19] = '{mk(0,0,1,0,0,0,0,0,0,IRM,0), 1, 64'h302, 64'h30C,
                 mkd(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h302)};

    m_pred = 64'h0;
    m_d = bub();
    @(negedge Clk);

    for (int k = 0; k < 20; k++) begin
      run_cycle(vecs[k].i, a);
      if (vecs[k].chk_addr) chk($sformatf("vec%0d imem_addr", k), a, vecs[k].addr);
      chk_state($sformatf("vec%0d", k), vecs[k].pred, vecs[k].d);
    end

    for (int n = 0; n < 400; n++) begin
      b0 = 8'($urandom);
      r = mk(($urandom_range(31) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0),
             ($urandom_range(7) == 0),
             ($urandom_range(2) == 0) ? 4'h7 : 4'($urandom),
             1'($urandom), {$urandom, $urandom},
             ($urandom_range(3) == 0) ? 4'h9 : 4'($urandom),
             {$urandom, $urandom},
             {16'($urandom), $urandom, $urandom[23:0], b0},
             ($urandom_range(15) == 0));
      run_cycle(r, a);
      chk($sformatf("rnd%0d imem_addr", n), a, m_addr);
      chk_state($sformatf("rnd%0d", n), m_pred, m_d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
